// File: rtl/billiard_fx_pkg.sv
// Shared fixed-point types and FSM states for the billiard physics datapath.
// Defaults are Q2.30 on a 32-bit word.
package billiard_fx_pkg;

    localparam int FX_N    = 32;
    localparam int FX_FRAC = 30;

    typedef logic signed [FX_N-1:0] fx_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL_X,
        MUL_Y,
        MUL_Z,
        DONE
    } norm_sqr_state_t;

endpackage

// File: rtl/fx_sqr_acc.sv
// Signed fixed-point square, rescaled by FRAC_WIDTH, feeding a
// clearable accumulator wide enough that three squares never overflow.
module fx_sqr_acc #(
    parameter int N          = 32,
    parameter int FRAC_WIDTH = 30,
    parameter int ACC_W      = 2*N-FRAC_WIDTH+2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [N-1:0]  operand,
    output logic [ACC_W-1:0]     acc
);

    localparam int SH_W = 2*N-FRAC_WIDTH;

    logic signed [2*N-1:0]  op_ext;
    logic signed [2*N-1:0]  product;
    logic signed [SH_W-1:0] scaled;

    assign op_ext  = (2*N)'(operand);
    assign product = op_ext * op_ext;
    assign scaled  = SH_W'(product >>> FRAC_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(scaled);
        end
    end

endmodule

// File: rtl/norm_sqr_arbiter.sv
// Round-robin shared x^2+y^2+z^2 engine, one multiply per cycle.
// Define NORM_SQR_SAT_EN to saturate results above 2^(N-1)-1 instead of wrapping.
module norm_sqr_arbiter
    import billiard_fx_pkg::*;
#(
    parameter int N          = FX_N,
    parameter int FRAC_WIDTH = FX_FRAC,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_x,
    input  logic [NUM_REQ*N-1:0] req_y,
    input  logic [NUM_REQ*N-1:0] req_z,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [N-1:0]         resp_sum
);

    localparam int ACC_W = 2*N-FRAC_WIDTH+2;

    norm_sqr_state_t state, state_d;

    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               grant_any;
    logic [ID_W-1:0]    id_q;
    logic [N-1:0]       x_q, y_q, z_q;
    logic [N-1:0]       operand;
    logic               accept;
    logic               acc_en;
    logic [ACC_W-1:0]   acc;
    logic [N-1:0]       sum_d;

    // Search starts one past the last served id so every requester rotates.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        acc_en     = 1'b0;
        operand    = '0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = MUL_X;
                end
            end
            MUL_X: begin
                operand = x_q;
                acc_en  = 1'b1;
                state_d = MUL_Y;
            end
            MUL_Y: begin
                operand = y_q;
                acc_en  = 1'b1;
                state_d = MUL_Z;
            end
            MUL_Z: begin
                operand = z_q;
                acc_en  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ-1);
            id_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
        end else begin
            if (accept) begin
                id_q <= grant_idx;
                x_q  <= req_x[grant_idx*N +: N];
                y_q  <= req_y[grant_idx*N +: N];
                z_q  <= req_z[grant_idx*N +: N];
            end
            if (state == DONE && resp_ready) begin
                last_grant <= id_q;
            end
        end
    end

    fx_sqr_acc #(
        .N          (N),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_W      (ACC_W)
    ) u_sqr_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (acc_en),
        .operand (operand),
        .acc     (acc)
    );

`ifdef NORM_SQR_SAT_EN
    // Accumulator is never negative, so any set bit at or above N-1 is overflow.
    assign sum_d = (|acc[ACC_W-1:N-1]) ? {1'b0, {(N-1){1'b1}}} : acc[N-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^acc[ACC_W-1:N];
    assign sum_d     = acc[N-1:0];
`endif

    assign resp_sum = (state == DONE) ? sum_d : '0;
    assign resp_id  = id_q;

endmodule

// File: tb/tb_norm_sqr_arbiter.sv
// Scoreboard bench for norm_sqr_arbiter: expected sums pushed at each
// accept from an integer model, popped and compared at each response.
module tb_norm_sqr_arbiter;
    import billiard_fx_pkg::*;

    localparam int NR = 4;
    localparam int W  = 32;

`ifdef NORM_SQR_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'hB000_0000;
`endif

    typedef struct {
        int          id;
        logic [31:0] sum;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_x = '0;
    logic [NR*W-1:0] req_y = '0;
    logic [NR*W-1:0] req_z = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [1:0]      resp_id;
    logic [W-1:0]    resp_sum;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    logic prev_rv = 1'b0;
    logic prev_rr = 1'b0;
    logic [31:0] prev_sum = '0;
    logic [1:0]  prev_id = '0;

    norm_sqr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_z      (req_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input fx_t x, input fx_t y,
                                          input fx_t z);
        longint s;
        s = ((longint'(x) * longint'(x)) >>> 30)
          + ((longint'(y) * longint'(y)) >>> 30)
          + ((longint'(z) * longint'(z)) >>> 30);
`ifdef NORM_SQR_SAT_EN
        if (s > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
`endif
        return s[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_rv = 1'b0;
            prev_rr = 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, model(req_x[i*W +: W], req_y[i*W +: W],
                                            req_z[i*W +: W])});
                    acc_cyc = cyc;
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
            if (req_ready != '0)
                check("ready_onehot", 64'($onehot(req_ready)), 1);
            if (resp_valid && !prev_rv)
                check("latency", cyc, acc_cyc + 4);
            if (resp_valid && prev_rv && !prev_rr) begin
                check("hold_sum", resp_sum, prev_sum);
                check("hold_id", resp_id, prev_id);
            end
            if (resp_valid)
                check("ready_in_done", req_ready, 0);
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", resp_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_sum", resp_sum, e.sum);
                end
            end
            prev_rv  = resp_valid;
            prev_rr  = resp_ready;
            prev_sum = resp_sum;
            prev_id  = resp_id;
        end
    end

    task automatic set_ops(input int id, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z);
        req_x[id*W +: W] = x;
        req_y[id*W +: W] = y;
        req_z[id*W +: W] = z;
    endtask

    task automatic wait_grant(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 30);
        if (!req_ready[id]) check("grant_wait", req_ready[id], 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic do_single(input int id, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] z,
                             input logic [31:0] exp);
        int n = 0;
        @(posedge clk); #1;
        set_ops(id, x, y, z);
        resp_ready = 1'b1;
        req_valid  = NR'(1 << id);
        wait_grant(id);
        @(posedge clk); #1;
        req_valid = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(resp_valid && resp_ready) && n < 20);
        check("known_sum", resp_sum, exp);
        check("known_id", resp_id, id);
        @(posedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] h_sum;
        logic [1:0]  h_id;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_id", resp_id, 0);
        check("rst_sum", resp_sum, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_single(0, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000,
                  32'h3000_0000);
        do_single(0, 32'hE000_0000, 32'h4000_0000, 32'h0000_0000,
                  32'h5000_0000);
        do_single(0, 32'h6000_0000, 32'h6000_0000, 32'h6000_0000, OVF_EXP);

        // round robin with all requesters active
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < NR; i++)
            set_ops(i, $urandom_range(0, 32'h1FFF_FFFF),
                    -$urandom_range(0, 32'h1FFF_FFFF),
                    $urandom_range(0, 32'h1FFF_FFFF));
        resp_ready = 1'b1;
        req_valid  = '1;
        n = 0;
        while (grant_log.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("rr_count", grant_log.size(), 5);
        for (int j = 0; j < 5 && j < grant_log.size(); j++)
            check("rr_order", grant_log[j], j % NR);
        for (int j = 1; j < 5 && j < grant_cyc.size(); j++)
            check("rr_gap", grant_cyc[j] - grant_cyc[j-1], 5);
        drain();

        // backpressure in DONE with requester 1 pending
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_ops(0, 32'h1000_0000, 32'h3000_0000, 32'hF000_0000);
        set_ops(1, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
        req_valid = 4'b0001;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check("bp_valid", resp_valid, 1);
        h_sum = resp_sum;
        h_id  = resp_id;
        repeat (10) begin
            @(negedge clk);
            check("bp_sum", resp_sum, h_sum);
            check("bp_id", resp_id, h_id);
            check("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_regrant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // reset in MUL_Y discards the in-flight request
        do_reset();
        set_ops(2, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000);
        req_valid = 4'b0100;
        wait_grant(2);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_id", resp_id, 0);
        check("mid_rst_sum", resp_sum, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ops(0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
        req_valid = 4'b0101;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        check("post_rst_grant", req_ready, 4'b0001);
        drain();

        // random traffic, full-range operands, random backpressure
        repeat (80) begin
            @(posedge clk); #1;
            req_valid  = NR'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++)
                set_ops(i, $urandom, $urandom, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/norm_sqr_arbiter.md
# norm_sqr_arbiter

Shared squared-magnitude engine for the billiard physics datapath. It arbitrates round-robin among NUM_REQ requesters, each presenting a signed fixed-point 3-vector, and computes x²+y²+z² over three cycles on one signed multiplier. Each result is returned with the requester's id. It sits between the per-ball collision/velocity units and the single multiplier resource they share.

## Interface
- N, 32: operand/result width, signed fixed point.
- FRAC_WIDTH, 30: fractional bits (Q2.30 by default).
- NUM_REQ, 4: number of requesters (≥2).
- ID_W, $clog2(NUM_REQ): response id width.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: per-requester request valid.
- req_ready  out  NUM_REQ: one-hot grant/accept pulse.
- req_x, req_y, req_z  in  NUM_REQ*N each: packed operands; requester i occupies bits [i*N +: N].
- resp_valid  out  1: result valid.
- resp_ready  in  1: downstream accepts result.
- resp_id  out  ID_W: index of the requester served.
- resp_sum  out  N: squared magnitude, Q(N-FRAC_WIDTH).FRAC_WIDTH.

## Operation
- FSM states: IDLE, MUL_X, MUL_Y, MUL_Z, DONE.
- IDLE: if any req_valid is high, grant the first valid requester at or after (last_grant+1) mod NUM_REQ.
  - Drive req_ready[g]=1 combinationally in that cycle. The request transfers when req_valid[g] && req_ready[g].
  - Latch x, y, z and the id; clear the accumulator; go to MUL_X.
- MUL_X/MUL_Y/MUL_Z: multiply the latched component by itself (2N-bit signed product). Take product[2N-1:FRAC_WIDTH] (arithmetic shift right by FRAC_WIDTH) and add it to the accumulator. Advance to the next state; MUL_Z goes to DONE.
- Accumulator width is 2N-FRAC_WIDTH+2 bits, so no internal overflow occurs.
- DONE: resp_valid=1. resp_sum and resp_id are held stable until resp_ready. On the handshake, update last_grant to the served id and go to IDLE.
- Output range: the result is always ≥0. If the accumulator exceeds 2^(N-1)-1, the result is handled per Configuration.
- req_ready is 0 in every state except IDLE. Requests stay pending (valid held) until granted. Requester inputs are not sampled outside the accept cycle.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 services.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_sum=0. State=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- Latency: accept at cycle T gives resp_valid at T+4.
- Throughput: one result per 5 cycles minimum (accept, 3 multiply, DONE with immediate resp_ready). The return to IDLE costs one cycle; no accept occurs in DONE.
- Backpressure: DONE holds indefinitely while resp_ready=0; no new grant is issued.
- Simultaneous requests: only one grant per accept cycle; the others stay pending.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The in-flight result is discarded and no resp_valid is emitted for it.
- A req_valid dropped before its grant is not an error; that requester is skipped.

## Configuration
- NORM_SQR_SAT_EN defined: a result above 2^(N-1)-1 saturates to 2^(N-1)-1 (0x7FFF_FFFF at N=32).
- NORM_SQR_SAT_EN undefined: resp_sum = accumulator[N-1:0] (two's-complement wrap). Callers guarantee |v|² < 2^(N-FRAC_WIDTH-1).

## Structure
- Shared package billiard_fx_pkg holds:
  - N and FRAC_WIDTH defaults.
  - The FSM state enum (norm_sqr_state_t).
  - A fixed-point typedef fx_t (signed [N-1:0]).
- One sub-module, fx_sqr_acc: a combinational signed square with shift-by-FRAC_WIDTH, plus the registered accumulator with clear/enable. The top keeps the arbiter and FSM.

## Test plan
- Single request, Q2.30: req 0 with x=y=z=0x2000_0000 (0.5), resp_ready=1.
  - Expect resp_valid at T+4, resp_sum=0x3000_0000 (0.75), resp_id=0.
- Negative operands: x=0xE000_0000 (-0.5), y=0x4000_0000 (1.0), z=0.
  - Expect resp_sum=0x5000_0000 (1.25).
- Overflow: x=y=z=0x6000_0000 (1.5).
  - With NORM_SQR_SAT_EN, expect 0x7FFF_FFFF.
  - Without it, expect 0xB000_0000.
- Round-robin: all four req_valid held high, resp_ready=1.
  - Expect grants in order 0,1,2,3,0, with resp_id matching and results 5 cycles apart.
- Backpressure: resp_ready=0 for 10 cycles in DONE while req 1 is valid.
  - Expect resp_sum/resp_id stable and req_ready=0.
  - After release, req 1 is granted the cycle after IDLE is re-entered.
- Reset mid-operation: assert rst_n=0 in MUL_Y.
  - Expect all outputs 0 immediately and no response for that request.
  - After release, the next grant goes to requester 0.
